// File: rtl/accu_sum_buffer.sv
// accu_sum_buffer
// Downstream stage for the 4-sample accumulator. Each group sum arriving on a
// one-cycle valid_in pulse is captured into a small first-word-fall-through
// FIFO and offered to a consumer over a valid/ready handshake. The accumulator
// cannot be stalled, so a sum that arrives while the FIFO is full and not
// being drained is dropped, and the sticky overflow flag records the loss.
//
// Optional feature: define ACCU_SUM_BUF_AVG_EN to store the rounded mean of
// each 4-sample sum, (data_in + 2) >> 2, instead of the raw sum.
//
// Parameters: DEPTH must be a power of two from 2 to 16, and LW must equal
// log2(DEPTH)+1 so that level can represent the completely full state.

module accu_sum_buffer #(
   parameter int DEPTH = 4,
   parameter int LW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [9:0]    data_in,
   input  logic          valid_in,
   input  logic          ready_in,
   input  logic          clr_ovf,
   output logic [9:0]    data_out,
   output logic          valid_out,
   output logic          full,
   output logic [LW-1:0] level,
   output logic          overflow
);

   localparam int PW = $clog2(DEPTH);

   logic [9:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic          overflow_q;

   logic          not_empty;
   logic          is_full;
   logic          push;
   logic          pop;
   logic          drop;
   logic [9:0]    wr_data;

   // Status flags come from the registered level only, so no handshake input
   // ever reaches an output combinationally.
   always_comb begin
      not_empty = 1'b0;
      is_full   = 1'b0;
      not_empty = (level_q != '0);
      is_full   = (level_q == LW'(DEPTH));
   end

   // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
   // that is being drained can still accept the incoming sum.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
      pop  = not_empty && ready_in;
      push = valid_in && (!is_full || pop);
      drop = valid_in && is_full && !pop;
   end

   // Value written into the array; the averaging form adds at 11 bits so the
   // rounding constant cannot wrap for the largest legal sum.
   always_comb begin
      wr_data = '0;
`ifdef ACCU_SUM_BUF_AVG_EN
      wr_data = 10'(({1'b0, data_in} + 11'd2) >> 2);
`else
      wr_data = data_in;
`endif
   end

   // Storage array; contents are don't-care after reset because the read
   // side is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Write pointer advances on every accepted sum and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PW'(1);
      end
   end

   // Read pointer advances on every completed consumer handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Occupancy counter; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Sticky loss flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clr_ovf) begin
         overflow_q <= 1'b0;
      end
   end

   // Output drive: the head entry falls through combinationally and is forced
   // to zero while empty so the reset value is well defined.
   always_comb begin
      data_out  = '0;
      valid_out = not_empty;
      full      = is_full;
      level     = level_q;
      overflow  = overflow_q;
      if (not_empty) begin
         data_out = mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_accu_sum_buffer.sv
// tb_accu_sum_buffer
// Scoreboard bench for accu_sum_buffer. A reference model samples the inputs
// on each rising edge, decides from plain occupancy arithmetic whether a sum
// is accepted or dropped, and queues the expected output value. A monitor on
// the falling edge compares status outputs against the model and checks each
// presented head entry against the front of the expected queue.

module tb_accu_sum_buffer;

   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic          clk;
   logic          rst_n;
   logic [9:0]    data_in;
   logic          valid_in;
   logic          ready_in;
   logic          clr_ovf;
   logic [9:0]    data_out;
   logic          valid_out;
   logic          full;
   logic [LW-1:0] level;
   logic          overflow;

   int totalCount;
   int badCount;

   int expectQ[$];
   int modelLevel;
   int modelOvf;

   accu_sum_buffer #(
      .DEPTH(DEPTH),
      .LW   (LW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .valid_in (valid_in),
      .ready_in (ready_in),
      .clr_ovf  (clr_ovf),
      .data_out (data_out),
      .valid_out(valid_out),
      .full     (full),
      .level    (level),
      .overflow (overflow)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Value the consumer should see for a given accepted sum.
   function automatic int expectValue(input int d);
`ifdef ACCU_SUM_BUF_AVG_EN
      return (d + 2) / 4;
`else
      return d;
`endif
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      totalCount++;
      if (actual != expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Applies one cycle of inputs just after a rising edge.
   task automatic applyStimulus(input logic v, input int d, input logic r, input logic c);
      @(posedge clk);
      #1;
      valid_in = v;
      data_in  = 10'(d);
      ready_in = r;
      clr_ovf  = c;
   endtask

   // Reference model: occupancy arithmetic on a queue of expected values.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expectQ.delete();
         modelLevel = 0;
         modelOvf   = 0;
      end else begin
         bit doPop;
         bit doPush;
         doPop  = (modelLevel > 0) && ready_in;
         doPush = valid_in && ((modelLevel < DEPTH) || doPop);
         if (doPush) begin
            expectQ.push_back(expectValue(int'(data_in)));
         end
         if (valid_in && !doPush) begin
            modelOvf = 1;
         end else if (clr_ovf) begin
            modelOvf = 0;
         end
         modelLevel = modelLevel + int'(doPush) - int'(doPop);
      end
   end

   // Monitor: status against the model, head entry against the scoreboard.
   always @(negedge clk) begin
      checkOutput("level", int'(level), modelLevel);
      checkOutput("full", int'(full), int'(modelLevel == DEPTH));
      checkOutput("valid_out", int'(valid_out), int'(modelLevel > 0));
      checkOutput("overflow", int'(overflow), modelOvf);
      if (valid_out) begin
         if (expectQ.size() == 0) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL unexpected_output: got %0d expected none at %0t", data_out, $time);
         end else begin
            checkOutput("data_out", int'(data_out), expectQ[0]);
            if (ready_in) begin
               void'(expectQ.pop_front());
            end
         end
      end
   end

   initial begin
      totalCount = 0;
      badCount   = 0;
      rst_n      = 1'b0;
      valid_in   = 1'b0;
      data_in    = '0;
      ready_in   = 1'b0;
      clr_ovf    = 1'b0;

      #3;
      checkOutput("rst_data_out", int'(data_out), 0);
      checkOutput("rst_valid_out", int'(valid_out), 0);
      checkOutput("rst_level", int'(level), 0);
      checkOutput("rst_full", int'(full), 0);
      checkOutput("rst_overflow", int'(overflow), 0);
      #19;
      rst_n = 1'b1;

      $display("[TB] single pulse with consumer ready");
      applyStimulus(1'b1, 600, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);

      $display("[TB] fill with consumer stalled, then drain");
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, i * 100, 1'b0, 1'b0);
         applyStimulus(1'b0, 0, 1'b0, 1'b0);
      end
      #2;
      checkOutput("filled_level", int'(level), 4);
      checkOutput("filled_full", int'(full), 1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0);
      end

      $display("[TB] drop while full, clear, push during pop");
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, i * 100 + 5, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 999, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      #2;
      checkOutput("drop_overflow", int'(overflow), 1);
      checkOutput("drop_level", int'(level), 4);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      #2;
      checkOutput("cleared_overflow", int'(overflow), 0);
      applyStimulus(1'b1, 777, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      #2;
      checkOutput("reuse_level", int'(level), 4);
      checkOutput("reuse_overflow", int'(overflow), 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0);
      end

`ifdef ACCU_SUM_BUF_AVG_EN
      $display("[TB] averaging boundary values");
      applyStimulus(1'b1, 1020, 1'b0, 1'b0);
      applyStimulus(1'b1, 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 2, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0);
      end
`endif

      $display("[TB] asynchronous reset with three entries stored");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 50 + i, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      checkOutput("pre_reset_level", int'(level), 3);
      rst_n = 1'b0;
      #1;
      checkOutput("async_valid_out", int'(valid_out), 0);
      checkOutput("async_level", int'(level), 0);
      checkOutput("async_data_out", int'(data_out), 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b1, 5, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 35), int'($urandom_range(0, 1020)),
                       1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0);
      end
      #2;
      checkOutput("final_valid_out", int'(valid_out), 0);
      checkOutput("final_pending", expectQ.size(), 0);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
